tx_iod_lane_ctrl: RTL and testbench

Per-lane sequencer for a 4:1 DDR TX IOD lane (8-bit TX_DATA, 4-bit OE_DATA, fabric-clock domain).
- Controls the lane's TX_SYNC_RST after PLL lock.
- Sends a training pattern until the far-end RX bit-align logic reports lock, then hands the lane to user data through a valid/ready handshake.
- Sits between user TX logic and the IOD TX wrapper; one instance per lane.

---
 rtl/tx_iod_lane_ctrl_pkg.sv | 21 ++
 rtl/tx_iod_lane_ctrl_if.sv | 10 +
 rtl/tx_iod_lane_ctrl_rst_sync_2ff.sv | 24 ++
 rtl/tx_iod_lane_ctrl.sv | 139 +++++++++++++
 tb/tb_tx_iod_lane_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_iod_lane_ctrl_pkg.sv
// Shared types and constants for the TX IOD lane sequencer.
// Holds the state encoding, OE constants and the counter sizing helper.
package tx_iod_lane_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRST  = 3'd1,
        ST_TRAIN = 3'd2,
        ST_DATA  = 3'd3,
        ST_ERROR = 3'd4
    } lane_state_e;

    localparam logic [3:0] OE_ALL  = 4'hF;
    localparam logic [3:0] OE_NONE = 4'h0;

    // Bits needed to hold every value 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tx_iod_lane_ctrl_if.sv
// User-side word handshake of one TX lane.
// master = user TX logic, slave = lane sequencer.
interface tx_iod_lane_ctrl_if;
    logic [7:0] TX_DATA_IN;
    logic       TX_DATA_VALID;
    logic       TX_DATA_READY;

    modport master (output TX_DATA_IN, output TX_DATA_VALID, input TX_DATA_READY);
    modport slave  (input TX_DATA_IN, input TX_DATA_VALID, output TX_DATA_READY);
endinterface

// File: rtl/tx_iod_lane_ctrl_rst_sync_2ff.sv
// Reset synchroniser: asserts asynchronously, releases after two clk edges.
// No data path; output is an active-low reset local to clk.
module rst_sync_2ff (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n_sync
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_sync = sync_q[1];
endmodule

// File: rtl/tx_iod_lane_ctrl.sv
// Per-lane TX IOD sequencer: sync reset, training pattern, then user data.
// Latency: accepted word appears on TX_DATA_0 one FAB_CLK after accept.
// Backpressure: TX_DATA_READY high only in DATA; no internal buffering.
module tx_iod_lane_ctrl
    import tx_iod_lane_pkg::*;
#(
    parameter int unsigned SYNC_RST_CYCLES  = 16,
    parameter int unsigned TRAIN_MIN_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYCLES   = 65535,
    parameter logic [7:0]  TRAIN_PATTERN    = 8'hF0,
    parameter logic [7:0]  IDLE_PATTERN     = 8'h00
) (
    input  logic                 FAB_CLK,
    input  logic                 ARST_N,
    input  logic                 PLL_LOCK,
    input  logic                 RESTART,
    input  logic                 TRAIN_DONE,
    tx_iod_lane_ctrl_if.slave    usr,
    output logic [7:0]           TX_DATA_0,
    output logic [3:0]           OE_DATA_0,
    output logic                 TX_SYNC_RST,
    output logic                 LANE_UP,
    output logic                 TRAIN_ERR,
    output logic [2:0]           STATE
);
    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] SRST_LAST  = CW'(SYNC_RST_CYCLES - 1);
    localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_MIN_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SRST  = ST_SRST;
    localparam logic [2:0] S_TRAIN = ST_TRAIN;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_ERROR = ST_ERROR;

    logic          rst_n;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [3:0]    oe_q, oe_d;
    logic          sync_rst_q, sync_rst_d;
    logic          lane_up_q, lane_up_d;
    logic          train_err_q, train_err_d;
    logic          accept;

    rst_sync_2ff u_rst_sync (
        .clk        (FAB_CLK),
        .arst_n     (ARST_N),
        .rst_n_sync (rst_n)
    );

    assign accept = usr.TX_DATA_VALID && (state_q == S_DATA);

    always_comb begin
        state_d = state_q;
        if (!PLL_LOCK && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else if (RESTART) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (PLL_LOCK) state_d = S_SRST;
                S_SRST:  if (cnt_q >= SRST_LAST) state_d = S_TRAIN;
                S_TRAIN: begin
                    // An in-window TRAIN_DONE beats a coincident timeout.
                    if (TRAIN_DONE && (cnt_q >= TRAIN_LAST)) state_d = S_DATA;
                    else if (cnt_q >= TMO_LAST)              state_d = S_ERROR;
                end
                S_DATA:  state_d = S_DATA;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + CW'(1);
    end

    // Outputs are registered from the next state so they always agree with STATE.
    always_comb begin
        tx_data_d   = IDLE_PATTERN;
        oe_d        = OE_NONE;
        sync_rst_d  = 1'b0;
        lane_up_d   = 1'b0;
        train_err_d = train_err_q;
        case (state_d)
            S_IDLE, S_SRST: sync_rst_d = 1'b1;
            S_TRAIN: begin
                tx_data_d = TRAIN_PATTERN;
                oe_d      = OE_ALL;
            end
            S_DATA: begin
                oe_d      = OE_ALL;
                lane_up_d = 1'b1;
                if (accept) tx_data_d = usr.TX_DATA_IN;
            end
            default: begin
                tx_data_d = IDLE_PATTERN;
                oe_d      = OE_NONE;
            end
        endcase
        if (RESTART)                                           train_err_d = 1'b0;
        else if ((state_q == S_TRAIN) && (state_d == S_ERROR)) train_err_d = 1'b1;
    end

    always_ff @(posedge FAB_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tx_data_q   <= IDLE_PATTERN;
            oe_q        <= OE_NONE;
            sync_rst_q  <= 1'b1;
            lane_up_q   <= 1'b0;
            train_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            oe_q        <= oe_d;
            sync_rst_q  <= sync_rst_d;
            lane_up_q   <= lane_up_d;
            train_err_q <= train_err_d;
        end
    end

    assign usr.TX_DATA_READY = (state_q == S_DATA);
    assign TX_DATA_0         = tx_data_q;
    assign OE_DATA_0         = oe_q;
    assign TX_SYNC_RST       = sync_rst_q;
    assign LANE_UP           = lane_up_q;
    assign TRAIN_ERR         = train_err_q;
    assign STATE             = state_q;
endmodule

// File: tb/tb_tx_iod_lane_ctrl.sv
// Directed + randomized bench for tx_iod_lane_ctrl with a spec-level expectation model.
module tb_tx_iod_lane_ctrl;
    localparam int SYNC_N = 16;
    localparam int MIN_N  = 64;
    localparam int TMO_N  = 200;

    localparam logic [2:0] E_IDLE  = 3'd0;
    localparam logic [2:0] E_SRST  = 3'd1;
    localparam logic [2:0] E_TRAIN = 3'd2;
    localparam logic [2:0] E_DATA  = 3'd3;
    localparam logic [2:0] E_ERROR = 3'd4;
    localparam logic [7:0] PAT_T   = 8'hF0;
    localparam logic [7:0] PAT_I   = 8'h00;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N, PLL_LOCK, RESTART, TRAIN_DONE;
    logic [7:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       TX_SYNC_RST, LANE_UP, TRAIN_ERR;
    logic [2:0] STATE;

    int checks   = 0;
    int failures = 0;

    tx_iod_lane_ctrl_if usr_if ();

    tx_iod_lane_ctrl #(
        .SYNC_RST_CYCLES  (SYNC_N),
        .TRAIN_MIN_CYCLES (MIN_N),
        .TIMEOUT_CYCLES   (TMO_N),
        .TRAIN_PATTERN    (8'hF0),
        .IDLE_PATTERN     (8'h00)
    ) dut (
        .FAB_CLK     (FAB_CLK),
        .ARST_N      (ARST_N),
        .PLL_LOCK    (PLL_LOCK),
        .RESTART     (RESTART),
        .TRAIN_DONE  (TRAIN_DONE),
        .usr         (usr_if),
        .TX_DATA_0   (TX_DATA_0),
        .OE_DATA_0   (OE_DATA_0),
        .TX_SYNC_RST (TX_SYNC_RST),
        .LANE_UP     (LANE_UP),
        .TRAIN_ERR   (TRAIN_ERR),
        .STATE       (STATE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic srst,
                           input logic [7:0] dat, input logic [3:0] oe, input logic rdy,
                           input logic up, input logic err);
        chk({tag, "_state"}, 32'(STATE), 32'(st));
        chk({tag, "_srst"},  32'(TX_SYNC_RST), 32'(srst));
        chk({tag, "_data"},  32'(TX_DATA_0), 32'(dat));
        chk({tag, "_oe"},    32'(OE_DATA_0), 32'(oe));
        chk({tag, "_ready"}, 32'(usr_if.TX_DATA_READY), 32'(rdy));
        chk({tag, "_laneup"}, 32'(LANE_UP), 32'(up));
        chk({tag, "_err"},   32'(TRAIN_ERR), 32'(err));
    endtask

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc);
        int n = 0;
        while ((STATE !== st) && (n < max_cyc)) begin
            step();
            n++;
        end
        chk(tag, 32'(STATE), 32'(st));
    endtask

    // Called right after the first SRST cycle has been observed.
    task automatic srst_to_train(input string tag);
        for (int i = 1; i < SYNC_N; i++) begin
            step();
            chk({tag, "_srst_state"}, 32'(STATE), 32'(E_SRST));
            chk({tag, "_srst_pin"}, 32'(TX_SYNC_RST), 32'd1);
        end
        step();
        chk_out({tag, "_train_entry"}, E_TRAIN, 1'b0, PAT_T, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] dat_tbl [4];
    logic       vld_tbl [4];
    logic [7:0] d;
    logic       v;
    logic [2:0] exp_st;
    int         kd;

    initial begin
        dat_tbl = '{8'hA5, 8'h3C, 8'hEE, 8'h81};
        vld_tbl = '{1'b1, 1'b1, 1'b0, 1'b1};
        ARST_N = 1'b0; PLL_LOCK = 1'b0; RESTART = 1'b0; TRAIN_DONE = 1'b0;
        usr_if.TX_DATA_IN = 8'h00; usr_if.TX_DATA_VALID = 1'b0;

        repeat (3) step();
        chk_out("reset", E_IDLE, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);
        ARST_N = 1'b1;
        repeat (5) step();
        chk_out("idle_nolock", E_IDLE, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);

        // Power-up: SRST lasts exactly SYNC_N cycles.
        PLL_LOCK = 1'b1;
        step();
        chk_out("srst_entry", E_SRST, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);
        srst_to_train("pwrup");

        // Early TRAIN_DONE pulse at cycle 10 is not latched; cycle 70 is honoured.
        for (int k = 0; k < 70; k++) begin
            TRAIN_DONE = (k == 10);
            step();
            chk("early_done_ignored", 32'(STATE), 32'(E_TRAIN));
        end
        TRAIN_DONE = 1'b1;
        step();
        chk_out("lane_up", E_DATA, 1'b0, PAT_I, 4'hF, 1'b1, 1'b1, 1'b0);
        TRAIN_DONE = 1'b0;

        // Directed streaming beats, then random beats with TRAIN_DONE wiggling.
        for (int i = 0; i < 4; i++) begin
            chk("stream_ready", 32'(usr_if.TX_DATA_READY), 32'd1);
            usr_if.TX_DATA_VALID = vld_tbl[i];
            usr_if.TX_DATA_IN    = dat_tbl[i];
            step();
            chk("stream_dir", 32'(TX_DATA_0), 32'(vld_tbl[i] ? dat_tbl[i] : PAT_I));
        end
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            usr_if.TX_DATA_VALID = v;
            usr_if.TX_DATA_IN    = d;
            TRAIN_DONE = 1'($urandom_range(0, 1));
            step();
            chk("stream_rnd_data", 32'(TX_DATA_0), 32'(v ? d : PAT_I));
            chk("stream_rnd_state", 32'(STATE), 32'(E_DATA));
            chk("stream_rnd_ready", 32'(usr_if.TX_DATA_READY), 32'd1);
        end
        TRAIN_DONE = 1'b0;

        // RESTART with a beat in flight: word is dropped, lane resequences.
        usr_if.TX_DATA_VALID = 1'b1; usr_if.TX_DATA_IN = 8'h5A; RESTART = 1'b1;
        step();
        chk_out("restart_data", E_IDLE, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);
        RESTART = 1'b0; usr_if.TX_DATA_VALID = 1'b0;
        step();
        chk("restart_resrst", 32'(STATE), 32'(E_SRST));
        srst_to_train("restart");

        // Random early glitches, then done at a random in-window cycle.
        kd = MIN_N - 1 + int'($urandom_range(0, 20));
        for (int k = 0; k <= kd; k++) begin
            TRAIN_DONE = (k < MIN_N - 1) ? 1'($urandom_range(0, 1)) : (k == kd);
            exp_st = (k == kd) ? E_DATA : E_TRAIN;
            step();
            chk("rnd_train", 32'(STATE), 32'(exp_st));
        end
        TRAIN_DONE = 1'b0;

        // Lock loss mid-DATA with VALID high.
        usr_if.TX_DATA_VALID = 1'b1; usr_if.TX_DATA_IN = 8'h77; PLL_LOCK = 1'b0;
        step();
        chk_out("lockloss", E_IDLE, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);
        usr_if.TX_DATA_VALID = 1'b0;
        step();
        chk("lockloss_hold", 32'(STATE), 32'(E_IDLE));
        PLL_LOCK = 1'b1;
        step();
        chk("relock_srst", 32'(STATE), 32'(E_SRST));
        srst_to_train("relock");

        // Timeout: ERROR on TRAIN cycle TMO_N.
        for (int k = 0; k < TMO_N; k++) begin
            step();
            if (k < TMO_N - 1) chk("timeout_train", 32'(STATE), 32'(E_TRAIN));
        end
        chk_out("timeout", E_ERROR, 1'b0, PAT_I, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            TRAIN_DONE = 1'($urandom_range(0, 1));
            step();
            chk("error_hold_state", 32'(STATE), 32'(E_ERROR));
            chk("error_hold_err", 32'(TRAIN_ERR), 32'd1);
        end
        TRAIN_DONE = 1'b0; RESTART = 1'b1;
        step();
        chk_out("restart_err", E_IDLE, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);
        RESTART = 1'b0;
        step();
        chk("post_err_srst", 32'(STATE), 32'(E_SRST));
        srst_to_train("post_err");

        // Async reset mid-TRAIN takes effect without a clock edge.
        repeat (20) step();
        #2 ARST_N = 1'b0;
        #1;
        chk_out("async_rst", E_IDLE, 1'b1, PAT_I, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        ARST_N = 1'b1;
        wait_state("post_arst_srst", E_SRST, 8);
        srst_to_train("post_arst");

        // Done and timeout coincide on the last TRAIN cycle: done wins.
        for (int k = 0; k < TMO_N; k++) begin
            TRAIN_DONE = (k == TMO_N - 1);
            exp_st = (k == TMO_N - 1) ? E_DATA : E_TRAIN;
            step();
            chk("done_vs_tmo", 32'(STATE), 32'(exp_st));
        end
        chk_out("done_wins", E_DATA, 1'b0, PAT_I, 4'hF, 1'b1, 1'b1, 1'b0);
        TRAIN_DONE = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
